// File: rtl/vga_fb_pkg.sv
// Shared types for the VGA framebuffer arbiter: FSM states and memory return tags.
package vga_fb_pkg;

  localparam int STATE_W = 1;
  localparam int TAG_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } state_t;

  typedef enum logic [TAG_W-1:0] {
    TAG_NONE   = 2'd0,
    TAG_DISP   = 2'd1,
    TAG_CLIENT = 2'd2
  } tag_t;

  function automatic int pipe_depth(input int mem_lat);
    return mem_lat + 1;
  endfunction

endpackage

// File: rtl/vga_fb_delay.sv
// Fixed-depth shift register with asynchronous clear, used for timing and tag pipes.
module vga_fb_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: even visible pixels fetch a 2-pixel word for
// the display, every other cycle is offered to the client.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int PIX_WIDTH  = 4,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HPOS_WIDTH-1:0]  hpos,
  input  logic [VPOS_WIDTH-1:0]  vpos,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   display_on,
  input  logic                   cl_req,
  input  logic                   cl_we,
  input  logic [ADDR_WIDTH-1:0]  cl_addr,
  input  logic [2*PIX_WIDTH-1:0] cl_wdata,
  output logic                   cl_ack,
  output logic [2*PIX_WIDTH-1:0] cl_rdata,
  output logic                   cl_rvalid,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [2*PIX_WIDTH-1:0] mem_wdata,
  input  logic [2*PIX_WIDTH-1:0] mem_rdata,
  output logic [PIX_WIDTH-1:0]   pix,
  output logic                   out_hsync,
  output logic                   out_vsync,
  output logic                   out_display_on,
  output logic [STATE_W-1:0]     dbg_state
);

  localparam int PIPE = pipe_depth(MEM_LAT);
  localparam int DW   = 2 * PIX_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(H_DISPLAY / 2 * V_DISPLAY - 1);

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  word_cnt;
  logic                   frame_start, live, disp_slot, grant;
  tag_t                   tag_in;
  logic [TAG_W-1:0]       tag_q;
  logic [2:0]             timing_q;
  logic [DW-1:0]          pair;
  logic                   half_hi;

  // The frame-origin cycle already counts as active so the first line of the
  // first frame after reset is fetched rather than skipped.
  assign frame_start = (hpos == '0) && (vpos == '0);
  assign live        = (state == ACTIVE) || frame_start;
  assign disp_slot   = live && display_on && !hpos[0];

  // Handshake: cl_req is held with stable cl_we/cl_addr/cl_wdata until a cycle in
  // which cl_ack=1; that same cycle carries the memory command. Read data returns
  // MEM_LAT cycles later as a one-cycle cl_rvalid pulse with cl_rdata.
  assign grant = cl_req && !disp_slot;

  always_comb begin
    state_nx = state;
    if (state == WAIT_SYNC && frame_start) state_nx = ACTIVE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_SYNC;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (frame_start) begin
      word_cnt <= disp_slot ? ADDR_WIDTH'(1) : '0;
    end else if (disp_slot) begin
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + ADDR_WIDTH'(1);
    end
  end

  // Memory command; everything is forced low while reset is asserted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cl_ack    = 1'b0;
    if (rst) begin
      if (disp_slot) begin
        mem_req  = 1'b1;
        mem_addr = frame_start ? '0 : word_cnt;
      end else if (grant) begin
        mem_req   = 1'b1;
        mem_we    = cl_we;
        mem_addr  = cl_addr;
        mem_wdata = cl_we ? cl_wdata : '0;
        cl_ack    = 1'b1;
      end
    end
  end

  always_comb begin
    tag_in = TAG_NONE;
    if (disp_slot)          tag_in = TAG_DISP;
    else if (grant && !cl_we) tag_in = TAG_CLIENT;
  end

  vga_fb_delay #(.WIDTH(TAG_W), .DEPTH(MEM_LAT)) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .d   (tag_in),
    .q   (tag_q)
  );

  vga_fb_delay #(.WIDTH(3), .DEPTH(PIPE)) u_timing_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({hsync, vsync, display_on}),
    .q   (timing_q)
  );

  assign {out_hsync, out_vsync, out_display_on} = timing_q;

  // A display return loads the pair; the low pixel shows next cycle, the high one after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair    <= '0;
      half_hi <= 1'b0;
    end else if (tag_q == TAG_DISP) begin
      pair    <= mem_rdata;
      half_hi <= 1'b0;
    end else begin
      half_hi <= 1'b1;
    end
  end

  always_comb begin
    pix = '0;
    if (out_display_on && state == ACTIVE)
      pix = half_hi ? pair[DW-1:PIX_WIDTH] : pair[PIX_WIDTH-1:0];
  end

  assign cl_rvalid = (tag_q == TAG_CLIENT);
  assign cl_rdata  = cl_rvalid ? mem_rdata : '0;
  assign dbg_state = state;

endmodule
